// File: rtl/mem_responder.sv
// Single-port word memory responder: word/half/byte access with RMW sub-word stores and error flagging.
// Latency: ack at T+1 (word write, error) or T+1+READ_LAT (read, sub-word write); req ignored while busy.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int READ_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int AW    = ADDR_BITS + 2;
  localparam logic [2:0] LAT_M1 = (READ_LAT == 0) ? 3'd0 : 3'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RWAIT, S_RESP, S_WR, S_MERGE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];

  logic                 bad_req;
  logic [ADDR_BITS-1:0] widx;
  logic [31:0]          word_rd;
  logic [4:0]           lane_sh;
  logic [31:0]          lane_mask;
  logic [31:0]          lane_rd;
  logic [31:0]          merged;
  logic                 mem_we;
  logic [31:0]          mem_wdat;

  // Request legality is judged on the live inputs so a bad request never leaves IDLE for RWAIT.
  always_comb begin
    bad_req = 1'b0;
    if (size == 2'b11)                         bad_req = 1'b1;
    if (size == 2'b00 && addr[1:0] != 2'b00)   bad_req = 1'b1;
    if (size == 2'b01 && addr[0])              bad_req = 1'b1;
    if (addr[31:AW] != '0)                     bad_req = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          if (bad_req)                  state_d = S_ERR;
          else if (we && size == 2'b00) state_d = S_WR;
          else if (READ_LAT == 0)       state_d = we ? S_MERGE : S_RESP;
          else                          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q >= LAT_M1) state_d = we_q ? S_MERGE : S_RESP;
        else                 cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane shift is in bits: half uses addr[1]*16, byte uses addr[1:0]*8.
  always_comb begin
    widx    = addr_q[AW-1:2];
    word_rd = mem_q[widx];
    lane_sh = (size_q == 2'b01) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   lane_mask = 32'hFFFF_FFFF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'h0000_00FF;
    endcase
    lane_rd = (word_rd >> lane_sh) & lane_mask;
    merged  = (word_rd & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
  end

  always_comb begin
    ack      = 1'b0;
    err      = 1'b0;
    busy     = (state_q != S_IDLE);
    rdata    = rdata_q;
    mem_we   = 1'b0;
    mem_wdat = merged;
    case (state_q)
      S_RESP:  begin ack = 1'b1; rdata = lane_rd; end
      S_ERR:   begin ack = 1'b1; err = 1'b1; rdata = '0; end
      S_WR:    begin ack = 1'b1; mem_we = 1'b1; mem_wdat = wdata_q; end
      S_MERGE: begin ack = 1'b1; mem_we = 1'b1; end
      default: ;
    endcase
    rdata_d = rdata;
  end

  // Storage is deliberately not reset; the only write port is the commit cycle.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[widx] <= mem_wdat;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single transactions plus back-to-back req and mid-RMW reset sequences.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, err, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;

  mem_responder #(.ADDR_BITS(8), .READ_LAT(1)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] r, input logic e, input int l);
    vec_t v;
    v.name = n; v.we = w; v.size = s; v.addr = a; v.wdata = d;
    v.exp_rdata = r; v.exp_err = e; v.exp_lat = l;
    vecs.push_back(v);
  endtask

  // Issues one request at a negedge and samples on each following negedge until ack.
  task automatic run_txn(input vec_t v);
    int cyc;
    logic [31:0] exp_r;
    @(negedge clock);
    req = 1'b1; we = v.we; size = v.size; addr = v.addr; wdata = v.wdata;
    @(posedge clock);
    #1 req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!ack && cyc < 20);
    exp_r = (v.we && !v.exp_err) ? last_rdata : v.exp_rdata;
    chk({v.name, " lat"},   32'(cyc),  32'(v.exp_lat));
    chk({v.name, " err"},   32'(err),  32'(v.exp_err));
    chk({v.name, " rdata"}, rdata,     exp_r);
    chk({v.name, " busy"},  32'(busy), 32'd1);
    last_rdata = exp_r;
    @(negedge clock);
    chk({v.name, " idle"},  32'({ack, busy}), 32'd0);
    chk({v.name, " hold"},  rdata, last_rdata);
  endtask

  initial begin
    logic [7:0] ack_seen, busy_seen;

    add("w0",        1, 2'b00, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         0, 1);
    add("t1_wr",     1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 1);
    add("t1_rd",     0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 2);
    add("t2_wb",     1, 2'b10, 32'h0000_0011, 32'h0000_00AA, 32'h0,         0, 2);
    add("t2_rw",     0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 0, 2);
    add("t2_rb",     0, 2'b10, 32'h0000_0013, 32'h0,         32'h0000_00DE, 0, 2);
    add("t3_wh",     1, 2'b01, 32'h0000_0012, 32'h0000_1234, 32'h0,         0, 2);
    add("t3_rw",     0, 2'b00, 32'h0000_0010, 32'h0,         32'h1234_AAEF, 0, 2);
    add("t3_rh",     0, 2'b01, 32'h0000_0012, 32'h0,         32'h0000_1234, 0, 2);
    add("e_word",    0, 2'b00, 32'h0000_0002, 32'h0,         32'h0,         1, 1);
    add("e_half_wr", 1, 2'b01, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0,         1, 1);
    add("e_size",    0, 2'b11, 32'h0000_0000, 32'h0,         32'h0,         1, 1);
    add("e_range",   0, 2'b10, 32'h0000_0400, 32'h0,         32'h0,         1, 1);
    add("r0",        0, 2'b00, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 0, 2);
    add("top_wr",    1, 2'b00, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         0, 1);
    add("top_rd",    0, 2'b00, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 0, 2);
    add("top_rb",    0, 2'b10, 32'h0000_03FF, 32'h0,         32'h0000_00CA, 0, 2);
    add("top_next",  0, 2'b00, 32'h0000_0400, 32'h0,         32'h0,         1, 1);
    add("hi_addr",   0, 2'b00, 32'h8000_0010, 32'h0,         32'h0,         1, 1);

    #1;
    chk("rst ack",   32'(ack),  32'd0);
    chk("rst err",   32'(err),  32'd0);
    chk("rst busy",  32'(busy), 32'd0);
    chk("rst rdata", rdata,     32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // req held for six edges over word reads at 0x10: accepts on edges 0 and 3.
    @(negedge clock);
    req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h10;
    ack_seen = '0; busy_seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      ack_seen[i]  = ack;
      busy_seen[i] = busy;
      if (ack) chk("hold rdata", rdata, 32'h1234_AAEF);
      if (i == 5) req = 1'b0;
    end
    chk("hold acks", 32'(ack_seen),  32'h12);
    chk("hold busy", 32'(busy_seen), 32'h1B);
    last_rdata = 32'h1234_AAEF;

    // Reset during the read phase of a byte RMW must abort with no write.
    @(negedge clock);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55;
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    chk("pre-rst busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid-rst outs", {rdata[29:0], ack, err}, 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    last_rdata = '0;
    begin
      vec_t v;
      v.name = "post_rst"; v.we = 0; v.size = 2'b00; v.addr = 32'h10; v.wdata = 0;
      v.exp_rdata = 32'h1234_AAEF; v.exp_err = 0; v.exp_lat = 2;
      run_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
